// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: three-flop line synchroniser, start-bit glitch rejection,
// mid-bit sampling, one-cycle done/frame-error strobes and a frame-busy level.
module uart_rx_frame #(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_rxd,
    output logic       uart_en,
    output logic       uart_done,
    output logic [7:0] uart_data,
    output logic       frame_err
);

    localparam int BPS_CNT  = CLK_FREQ / UART_BPS;
    localparam int HALF_CNT = BPS_CNT / 2;
    localparam int CNT_W    = $clog2(BPS_CNT);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t             r_state;
    logic               r_rxd_s1;
    logic               r_rxd_s2;
    logic               r_rxd_s3;
    logic [CNT_W-1:0]   r_clk_cnt;
    logic [3:0]         r_bit_cnt;
    logic [7:0]         r_rx_shift;
    logic               r_en;
    logic               r_done;
    logic               r_err;
    logic [7:0]         r_data;

    logic               w_rx_fall;
    logic               w_sample;
    logic               w_bit_end;

    assign w_rx_fall = r_rxd_s3 & ~r_rxd_s2;
    assign w_sample  = (r_clk_cnt == CNT_HALF);
    assign w_bit_end = (r_clk_cnt == CNT_LAST);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= StIdle;
            r_rxd_s1   <= 1'b1;
            r_rxd_s2   <= 1'b1;
            r_rxd_s3   <= 1'b1;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_en       <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_data     <= '0;
        end else begin
            r_rxd_s1 <= uart_rxd;
            r_rxd_s2 <= r_rxd_s1;
            r_rxd_s3 <= r_rxd_s2;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            // Busy level trails the state by one cycle, so it is still high in the strobe cycle.
            r_en     <= (r_state != StIdle);

            case (r_state)
                StIdle: begin
                    r_clk_cnt <= '0;
                    if (w_rx_fall) begin
                        r_state   <= StStart;
                        r_bit_cnt <= '0;
                    end
                end
                StStart: begin
                    if (w_sample && r_rxd_s2) begin
                        r_state   <= StIdle;
                        r_clk_cnt <= '0;
                    end else if (w_bit_end) begin
                        r_state   <= StData;
                        r_clk_cnt <= '0;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (w_sample) begin
                        r_rx_shift <= {r_rxd_s2, r_rx_shift[7:1]};
                        r_bit_cnt  <= r_bit_cnt + 4'd1;
                    end
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_cnt == 4'd8) begin
                            r_state <= StStop;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                StStop: begin
                    // Leave at mid stop bit so a back-to-back start edge is not missed.
                    if (w_sample) begin
                        r_state   <= StIdle;
                        r_clk_cnt <= '0;
                        if (r_rxd_s2) begin
                            r_data <= r_rx_shift;
                            r_done <= 1'b1;
                        end else begin
                            r_err  <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    r_clk_cnt <= '0;
                end
            endcase
        end
    end

    assign uart_en   = r_en;
    assign uart_done = r_done;
    assign uart_data = r_data;
    assign frame_err = r_err;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 16 clocks per bit; expected strobes are queued
// by the stimulus and checked by an independent monitor.
module tb_uart_rx_frame;

    localparam int BPS  = 16;
    localparam int HALF = 8;
    // Line driven low just after edge E0: synchroniser exposes the fall after E2, START is
    // entered at E3, STOP sample completes at E3 + 9*BPS + HALF, done is registered one edge later.
    localparam int DONE_LAT = 3 + 9 * BPS + HALF + 1;

    logic       sys_clk  = 1'b0;
    logic       sys_rst  = 1'b1;
    logic       uart_rxd = 1'b1;
    logic       uart_en;
    logic       uart_done;
    logic [7:0] uart_data;
    logic       frame_err;

    uart_rx_frame #(
        .CLK_FREQ (16),
        .UART_BPS (1)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .uart_rxd  (uart_rxd),
        .uart_en   (uart_en),
        .uart_done (uart_done),
        .uart_data (uart_data),
        .frame_err (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc++;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_data = 8'h00;
    logic       en_seen = 1'b0;
    logic       en_at_done = 1'b0;
    logic       en_after_done = 1'b1;
    int         last_done_cyc = -1;
    logic       prev_strobe = 1'b0;
    logic       prev_done = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic expect_done(input logic [7:0] b);
        sb_q.push_back({1'b0, b});
        model_data = b;
    endtask

    task automatic expect_err();
        sb_q.push_back({1'b1, model_data});
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        uart_rxd = 1'b0;
        tick(BPS);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            tick(BPS);
        end
        uart_rxd = stop_bit;
        tick(BPS);
        uart_rxd = 1'b1;
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every strobe.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (uart_done || frame_err) begin
                check("strobe_exclusive", {31'd0, uart_done & frame_err}, 32'd0);
                check("strobe_gap", {31'd0, prev_strobe}, 32'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got done=%0b err=%0b data=0x%0h expected none",
                             uart_done, frame_err, uart_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("strobe_kind", {31'd0, frame_err}, {31'd0, mon_e.is_err});
                    check("strobe_data", {24'd0, uart_data}, {24'd0, mon_e.data});
                end
                if (uart_done) begin
                    last_done_cyc = cyc;
                    en_at_done    = uart_en;
                end
            end
            if (uart_data != prev_data) check("data_with_done", {31'd0, uart_done}, 32'd1);
            if (prev_done) en_after_done = uart_en;
            if (uart_en) en_seen = 1'b1;
        end
        prev_strobe = uart_done | frame_err;
        prev_done   = uart_done;
        prev_data   = uart_data;
    end

    int t0;

    initial begin
        tick(3);
        @(negedge sys_clk);
        check("rst_en", {31'd0, uart_en}, 32'd0);
        check("rst_done", {31'd0, uart_done}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_data", {24'd0, uart_data}, 32'h00);
        tick(1);
        sys_rst = 1'b0;
        tick(5);

        // Plain frame.
        en_seen = 1'b0;
        expect_done(8'hA5);
        send(8'hA5, 1'b1);
        tick(BPS);
        check("t1_en_seen", {31'd0, en_seen}, 32'd1);
        check("t1_en_idle", {31'd0, uart_en}, 32'd0);
        check("t1_data", {24'd0, uart_data}, 32'hA5);

        // Bad stop bit: data must hold.
        expect_err();
        send(8'h55, 1'b0);
        tick(BPS);
        check("t4_data_held", {24'd0, uart_data}, 32'hA5);

        // Short start glitch.
        en_seen  = 1'b0;
        uart_rxd = 1'b0;
        tick(4);
        uart_rxd = 1'b1;
        tick(3 * BPS);
        check("t3_en_seen", {31'd0, en_seen}, 32'd1);
        check("t3_en_idle", {31'd0, uart_en}, 32'd0);
        check("t3_data", {24'd0, uart_data}, 32'hA5);

        // Back-to-back frames.
        expect_done(8'h3C);
        expect_done(8'hC3);
        send(8'h3C, 1'b1);
        send(8'hC3, 1'b1);
        tick(BPS);
        check("t2_data", {24'd0, uart_data}, 32'hC3);

        // Reset during data bit 4 of 0xFF.
        uart_rxd = 1'b0;
        tick(BPS);
        uart_rxd = 1'b1;
        tick(4 * BPS + HALF);
        sys_rst = 1'b1;
        tick(2);
        @(negedge sys_clk);
        check("t5_rst_data", {24'd0, uart_data}, 32'h00);
        check("t5_rst_en", {31'd0, uart_en}, 32'd0);
        tick(1);
        sys_rst    = 1'b0;
        model_data = 8'h00;
        tick(2 * BPS);
        check("t5_idle_after_abort", {31'd0, uart_en}, 32'd0);
        check("t5_data_cleared", {24'd0, uart_data}, 32'h00);
        expect_done(8'h0F);
        send(8'h0F, 1'b1);
        tick(BPS);
        check("t5_data", {24'd0, uart_data}, 32'h0F);

        // Latency and busy-level fall.
        expect_done(8'h00);
        last_done_cyc = -1;
        t0 = cyc;
        send(8'h00, 1'b1);
        tick(2);
        check("t6_latency", last_done_cyc - t0, DONE_LAT);
        check("t6_en_at_done", {31'd0, en_at_done}, 32'd1);
        check("t6_en_after_done", {31'd0, en_after_done}, 32'd0);

        tick(BPS);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- 8N1 UART receiver feeding the segment-display scanner and the FIR data path.
- Synchronises the asynchronous `uart_rxd` line, detects and validates the start bit, and samples each bit at mid-bit.
- Outputs:
  - `uart_en`, a frame-busy level whose rising edge the display scanner uses to show "LoAdEd".
  - A one-cycle `uart_done` strobe with the received byte.
  - A `frame_err` strobe for bad stop bits.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- UART_BPS, 115200, baud rate in bit/s.
- BPS_CNT, CLK_FREQ/UART_BPS (localparam), clocks per bit; must be >= 4.
- HALF_CNT, BPS_CNT/2 (localparam, integer divide), counter value at which a bit is sampled.

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- sys_rst  input  1  reset.
- uart_rxd  input  1  asynchronous serial line; idle high.
- uart_en  output  1  high while a frame is being received.
- uart_done  output  1  one-cycle strobe: `uart_data` holds a new valid byte.
- uart_data  output  8  last correctly received byte.
- frame_err  output  1  one-cycle strobe: stop bit sampled low.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - While `sys_rst` = 1, state = IDLE and all counters are 0.
  - Synchroniser flops reset to 1.
  - `uart_en` = 0, `uart_done` = 0, `frame_err` = 0, `uart_data` = 8'h00.
  - Reset mid-frame aborts the frame. No strobe is issued, and `uart_data` is cleared.
- Synchronisation: three-flop chain `rxd_s1` -> `rxd_s2` -> `rxd_s3`.
  - `rx_fall` = `rxd_s3` & ~`rxd_s2`.
  - All sampling uses `rxd_s2`.
- Baud counter `clk_cnt` (width = clog2(BPS_CNT)):
  - Counts 0..BPS_CNT-1 in every non-IDLE state, then wraps to 0.
  - Cleared on IDLE entry and on the IDLE -> START transition.
  - "Sample point" means `clk_cnt` == HALF_CNT.
- State machine IDLE, START, DATA, STOP, with transitions registered:
  - IDLE: on `rx_fall`, go to START with `clk_cnt` = 0 and `bit_cnt` = 0. Other line activity is ignored.
  - START: at the sample point, if `rxd_s2` = 1 it is a glitch; return to IDLE with no strobe. Otherwise, go to DATA when `clk_cnt` = BPS_CNT-1.
  - DATA: at each sample point, shift `rxd_s2` into `rx_shift` LSB first (bit0 received first). `bit_cnt` increments at each sample. After the 8th sample, go to STOP when `clk_cnt` = BPS_CNT-1.
  - STOP: at the sample point, return to IDLE in the same cycle, without waiting for end of bit, so back-to-back frames are caught.
    - If `rxd_s2` = 1: `uart_data` <= `rx_shift` and `uart_done` = 1 for exactly one cycle.
    - If `rxd_s2` = 0: `frame_err` = 1 for exactly one cycle and `uart_data` is held.
- `uart_en` is registered: 1 in START/DATA/STOP, 0 in IDLE.
  - Rises the cycle after the IDLE -> START transition.
  - Falls the cycle after the STOP sample or a START glitch.
- `uart_done` and `frame_err` are never both 1, and never high in consecutive cycles.
- `uart_data` changes only together with a `uart_done` strobe, or on reset.
- Line held low in IDLE after a frame (break) creates no new `rx_fall`, so the block stays in IDLE until the line returns high and falls again.
- Latency: from the `rx_fall` cycle to `uart_done` is 9*BPS_CNT + HALF_CNT + 1 cycles (±1 allowed; the bench checks a fixed value agreed with RTL).

Test Plan (use CLK_FREQ = 16, UART_BPS = 1, so BPS_CNT = 16 and HALF_CNT = 8):
1. Reset, then send 0xA5 as an 8N1 frame at 16 clk/bit -> `uart_en` high for the frame; one `uart_done` pulse; `uart_data` = 8'hA5; `frame_err` never asserts.
2. Send 0x3C immediately followed by 0xC3 with no idle gap -> two `uart_done` pulses; `uart_data` reads 8'h3C at the first and 8'hC3 at the second.
3. Drive a 4-cycle low glitch on an idle line -> `uart_en` pulses briefly and returns to 0; no `uart_done`, no `frame_err`; `uart_data` unchanged.
4. Send 0x55 with the stop bit driven low -> one `frame_err` pulse, no `uart_done`; `uart_data` keeps its previous value (0xA5 from test 1).
5. Assert `sys_rst` during data bit 4 of 0xFF, release, then send 0x0F -> no strobe for the aborted frame; `uart_data` = 8'h00 after reset, then 8'h0F with one `uart_done`.
6. Send 0x00 and check timing -> `uart_done` arrives exactly 9*16 + 8 + 1 = 153 cycles after the `rx_fall` cycle; `uart_en` deasserts the following cycle.
